// File: rtl/row_max_argmax_stream.sv
// Streaming row max/argmax: a registered comparator tree reduces each beat, and an
// accumulator folds the beats of a row into one {max, index} result behind a valid/ready port.
module row_max_argmax_stream #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 8,
  parameter int MAX_BEATS = 4,
  parameter int SIGNED    = 1,
  parameter int IDX_W     = $clog2(N * MAX_BEATS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N*BIT_WIDTH-1:0] i_data,
  input  logic [N-1:0]           i_mask,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [BIT_WIDTH-1:0]   o_max,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_empty,
  output logic                   o_overflow
);

  localparam int LW  = $clog2(N);
  localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BIT_WIDTH-1:0] EMPTY_MAX =
    (SIGNED != 0) ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : '0;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] val;
    logic [LW-1:0]        lane;
    logic                 any;
  } node_t;

  typedef struct packed {
    logic           vld;
    logic [BCW-1:0] beat;
    logic           first;
    logic           close;
    logic           ovf;
  } side_t;

  function automatic logic gt(input logic [BIT_WIDTH-1:0] a, input logic [BIT_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Lower-index child wins ties; a child with no valid lane never wins.
  function automatic node_t pick(input node_t lo, input node_t hi);
    node_t r;
    r     = (hi.any && (!lo.any || gt(hi.val, lo.val))) ? hi : lo;
    r.any = lo.any | hi.any;
    return r;
  endfunction

  logic           en;
  logic           accept;
  logic [BCW-1:0] beat_cnt;
  logic           at_cap;
  side_t          sd_in;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign accept  = i_valid && en;
  assign at_cap  = (beat_cnt == BCW'(MAX_BEATS - 1));
  assign sd_in   = {accept, beat_cnt, beat_cnt == '0, i_last || at_cap, !i_last && at_cap};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       beat_cnt <= '0;
    else if (accept) beat_cnt <= (i_last || at_cap) ? '0 : beat_cnt + 1'b1;
  end

  // Level 0 is the raw beat; each further level is one registered halving of the tree.
  for (genvar l = 0; l <= LW; l++) begin : g_lvl
    localparam int W = N >> l;
    node_t nd [W];
    side_t sd;
    if (l == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_lane
        assign nd[k] = {i_data[k*BIT_WIDTH +: BIT_WIDTH], LW'(k), i_mask[k]};
      end
      assign sd = sd_in;
    end else begin : g_cmp
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          sd <= '0;
          for (int k = 0; k < W; k++) nd[k] <= '0;
        end else if (en) begin
          sd <= g_lvl[l-1].sd;
          for (int k = 0; k < W; k++) nd[k] <= pick(g_lvl[l-1].nd[2*k], g_lvl[l-1].nd[2*k+1]);
        end
      end
    end
  end

  node_t                top;
  side_t                top_sd;
  logic [BIT_WIDTH-1:0] acc_val;
  logic [IDX_W-1:0]     acc_idx;
  logic                 acc_any;
  logic                 base_any;
  logic                 take;
  logic [BIT_WIDTH-1:0] new_val;
  logic [IDX_W-1:0]     new_idx;
  logic                 new_any;

  assign top    = g_lvl[LW].nd[0];
  assign top_sd = g_lvl[LW].sd;

  // Fold the reduced beat into the running row state; first beat of a row ignores old state.
  always_comb begin
    base_any = top_sd.first ? 1'b0 : acc_any;
    take     = top.any && (!base_any || gt(top.val, acc_val));
    new_val  = take ? top.val : acc_val;
    new_idx  = take ? IDX_W'({top_sd.beat, top.lane}) : acc_idx;
    new_any  = top.any || base_any;
  end

  // Accumulator and output register share this stage so a closing beat lands directly in the result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_val    <= '0;
      acc_idx    <= '0;
      acc_any    <= 1'b0;
      o_valid    <= 1'b0;
      o_max      <= '0;
      o_idx      <= '0;
      o_empty    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (en) begin
      o_valid <= 1'b0;
      if (top_sd.vld) begin
        if (top_sd.close) begin
          o_valid    <= 1'b1;
          o_max      <= new_any ? new_val : EMPTY_MAX;
          o_idx      <= new_any ? new_idx : '0;
          o_empty    <= !new_any;
          o_overflow <= top_sd.ovf;
          acc_val    <= '0;
          acc_idx    <= '0;
          acc_any    <= 1'b0;
        end else begin
          acc_val <= new_val;
          acc_idx <= new_idx;
          acc_any <= new_any;
        end
      end
    end
  end

endmodule

// File: tb/tb_row_max_argmax_stream.sv
// Bench for row_max_argmax_stream: directed rows plus randomized traffic, scored against
// a row-list reference model for a signed and an unsigned instance driven in parallel.
module tb_row_max_argmax_stream;

  localparam int BW = 16;
  localparam int N  = 8;
  localparam int MB = 4;
  localparam int IW = $clog2(N * MB);

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_valid = 1'b0;
  logic [N*BW-1:0] i_data = '0;
  logic [N-1:0]    i_mask = '0;
  logic            i_last = 1'b0;
  logic            i_ready = 1'b1;
  logic            o_ready, o_valid, o_empty, o_overflow;
  logic [BW-1:0]   o_max;
  logic [IW-1:0]   o_idx;
  logic            o_ready_u, o_valid_u, o_empty_u, o_overflow_u;
  logic [BW-1:0]   o_max_u;
  logic [IW-1:0]   o_idx_u;

  row_max_argmax_stream #(.BIT_WIDTH(BW), .N(N), .MAX_BEATS(MB), .SIGNED(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_mask(i_mask), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready), .o_max(o_max),
    .o_idx(o_idx), .o_empty(o_empty), .o_overflow(o_overflow));

  row_max_argmax_stream #(.BIT_WIDTH(BW), .N(N), .MAX_BEATS(MB), .SIGNED(0)) dut_u (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_u), .i_data(i_data),
    .i_mask(i_mask), .i_last(i_last), .o_valid(o_valid_u), .i_ready(i_ready), .o_max(o_max_u),
    .o_idx(o_idx_u), .o_empty(o_empty_u), .o_overflow(o_overflow_u));

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the row is a flat list of unmasked elements in global index order.
  typedef struct { logic [BW-1:0] v; int gi; } elem_t;
  typedef struct { logic [BW-1:0] ms, mu; int is, iu; logic emp, ovf; } exp_t;
  elem_t row_q[$];
  exp_t  exp_q[$];
  int    beats_in_row = 0;

  function automatic exp_t row_result(input logic ovf);
    exp_t r;
    r.ovf = ovf;
    r.emp = (row_q.size() == 0);
    r.ms = 16'h8000; r.is = 0; r.mu = 16'h0000; r.iu = 0;
    foreach (row_q[j]) begin
      if (j == 0 || $signed(row_q[j].v) > $signed(r.ms)) begin r.ms = row_q[j].v; r.is = row_q[j].gi; end
      if (j == 0 || row_q[j].v > r.mu) begin r.mu = row_q[j].v; r.iu = row_q[j].gi; end
    end
    return r;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst) begin
      row_q.delete();
      exp_q.delete();
      beats_in_row = 0;
    end else begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("max_s", o_max, e.ms);
          check("idx_s", o_idx, e.is);
          check("empty_s", o_empty, e.emp);
          check("ovf_s", o_overflow, e.ovf);
          check("valid_u", o_valid_u, 1);
          check("max_u", o_max_u, e.mu);
          check("idx_u", o_idx_u, e.iu);
          check("empty_u", o_empty_u, e.emp);
          check("ovf_u", o_overflow_u, e.ovf);
        end
      end
      if (i_valid && o_ready) begin
        for (int k = 0; k < N; k++)
          if (i_mask[k]) row_q.push_back('{v: i_data[k*BW +: BW], gi: beats_in_row*N + k});
        beats_in_row++;
        if (i_last || beats_in_row == MB) begin
          exp_q.push_back(row_result(!i_last && beats_in_row == MB));
          row_q.delete();
          beats_in_row = 0;
        end
      end
    end
  end

  function automatic logic [N*BW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic send(input logic [N*BW-1:0] d, input logic [N-1:0] m, input logic l);
    int t = 0;
    i_valid = 1'b1; i_data = d; i_mask = m; i_last = l;
    @(negedge i_clk);
    while (!o_ready && t < 300) begin @(negedge i_clk); t++; end
    check("send_accept", o_ready, 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!o_valid && t < 50) begin @(posedge i_clk); #1; t++; end
    check("wait_valid", o_valid, 1);
  endtask

  task automatic drain();
    int t = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && t < 300) begin @(posedge i_clk); #1; t++; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_max"}, o_max, 0);
    check({tag, "_idx"}, o_idx, 0);
    check({tag, "_empty"}, o_empty, 0);
    check({tag, "_ovf"}, o_overflow, 0);
  endtask

  logic          rand_done;
  logic [BW-1:0] hold_max;
  int            lat;

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check_zero_outputs("reset");
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("reset_ready", o_ready, 1);

    // T1: single beat, latency and result
    i_ready = 1'b0;
    send(pk(3, -7, 12, 5, 12, 0, -1, 4), 8'hFF, 1'b1);
    lat = 1;
    while (!o_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
    check("t1_latency", lat, 4);
    check("t1_max", o_max, 12);
    check("t1_idx", o_idx, 2);
    check("t1_empty", o_empty, 0);
    drain();

    // T2: equal maxima in different beats, first occurrence wins
    i_ready = 1'b0;
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b0);
    send(pk(0, 0, 0, 0, 0, 0, 9, 0), 8'hFF, 1'b0);
    send(pk(9, 2, 2, 2, 2, 2, 2, 2), 8'hFF, 1'b1);
    wait_valid();
    check("t2_max", o_max, 9);
    check("t2_idx", o_idx, 14);
    drain();

    // T3: masked lanes ignored, then an all-masked row
    i_ready = 1'b0;
    send(pk(5, -3, 20, 7, 0, 100, 1, 2), 8'h0F, 1'b1);
    wait_valid();
    check("t3_max", o_max, 20);
    check("t3_idx", o_idx, 2);
    drain();
    i_ready = 1'b0;
    send(pk(50, 60, 70, 80, 90, 1, 2, 3), 8'h00, 1'b1);
    wait_valid();
    check("t3_empty", o_empty, 1);
    check("t3_empty_max", o_max, 16'h8000);
    check("t3_empty_idx", o_idx, 0);
    check("t3_empty_max_u", o_max_u, 0);
    drain();

    // T4: signedness of compare
    i_ready = 1'b0;
    send(pk(16'hFFFF, 1, 0, 0, 0, 0, 0, 0), 8'hFF, 1'b1);
    wait_valid();
    check("t4_max_s", o_max, 1);
    check("t4_idx_s", o_idx, 1);
    check("t4_max_u", o_max_u, 16'hFFFF);
    check("t4_idx_u", o_idx_u, 0);
    drain();

    // T5: stall downstream while three one-beat rows stream in
    i_ready = 1'b0;
    send(pk(1, 2, 3, 4, 5, 6, 7, 30), 8'hFF, 1'b1);
    send(pk(40, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b1);
    send(pk(1, 2, 3, -50, 5, 6, 77, 8), 8'hFF, 1'b1);
    wait_valid();
    check("t5_ready_low", o_ready, 0);
    check("t5_ready_low_u", o_ready_u, 0);
    hold_max = o_max;
    repeat (5) @(posedge i_clk);
    #1;
    check("t5_hold_valid", o_valid, 1);
    check("t5_hold_max", o_max, hold_max);
    check("t5_hold_ready", o_ready, 0);
    drain();

    // T6: overflow close, new row after it, then reset mid-row
    i_ready = 1'b0;
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b0);
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b0);
    send(pk(1, 2, 3, 4, 5, 66, 7, 8), 8'hFF, 1'b0);
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b0);
    wait_valid();
    check("t6_overflow", o_overflow, 1);
    check("t6_ovf_max", o_max, 66);
    check("t6_ovf_idx", o_idx, 21);
    i_ready = 1'b1;
    send(pk(9, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b0);
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b1);
    drain();

    i_ready = 1'b0;
    send(pk(1, 2, 3, 77, 5, 6, 7, 8), 8'hFF, 1'b1);
    send(pk(500, 500, 500, 500, 500, 500, 500, 500), 8'hFF, 1'b0);
    send(pk(600, 600, 600, 600, 600, 600, 600, 600), 8'hFF, 1'b0);
    wait_valid();
    check("t6_pre_reset_idx", o_idx, 3);
    i_rst = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("post_reset_ready", o_ready, 1);
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b1);
    wait_valid();
    check("post_reset_max", o_max, 8);
    check("post_reset_idx", o_idx, 7);
    check("post_reset_ovf", o_overflow, 0);
    drain();

    // Randomized traffic with random downstream backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 400; b++) begin
          logic [N*BW-1:0] d;
          logic [N-1:0]    m;
          int              r;
          for (int k = 0; k < N; k++)
            d[k*BW +: BW] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                        : 16'($urandom_range(0, 6)) - 16'd3;
          r = $urandom_range(0, 9);
          m = (r == 0) ? 8'h00 : (r < 4) ? 8'hFF : 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin @(posedge i_clk); #1; end
          send(d, m, $urandom_range(0, 2) == 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    send(pk(0, 0, 0, 0, 0, 0, 0, 0), 8'hFF, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
